// File: rtl/jesd204_fec_encode_multilane_if.sv
// ---------------------------------------------------------------------------
// jesd204_fec_encode_multilane_if : stream bus for the multi-lane FEC parity generator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface jesd204_fec_encode_multilane_if #(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int FEC_WIDTH  = 26
);
   logic                            s_valid;
   logic                            s_ready;
   logic                            s_start;
   logic [NUM_LANES*DATA_WIDTH-1:0] s_data;
   logic                            m_valid;
   logic                            m_ready;
   logic [NUM_LANES*DATA_WIDTH-1:0] m_data;
   logic                            m_last;
   logic [NUM_LANES*FEC_WIDTH-1:0]  m_fec;
   logic                            align_err;

   modport master (
      output s_valid, s_start, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last, m_fec, align_err
   );

   modport slave (
      input  s_valid, s_start, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last, m_fec, align_err
   );
endinterface

`default_nettype wire

// File: rtl/jesd204_fec_encode_multilane.sv
// ---------------------------------------------------------------------------
// jesd204_fec_encode_multilane : per-lane 64B/66B FEC parity over 2048-bit blocks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jesd204_fec_encode_multilane #(
   parameter int                      NUM_LANES  = 4,
   parameter int                      DATA_WIDTH = 64,
   parameter int                      BLOCK_BITS = 2048,
   parameter int                      FEC_WIDTH  = 26,
   parameter logic [FEC_WIDTH-1:0]    FEC_POLY   = 26'h0220211
) (
   input  logic                           clk,
   input  logic                           rst,
   jesd204_fec_encode_multilane_if.slave  bus
);

   localparam int             WPB      = BLOCK_BITS / DATA_WIDTH;
   localparam int             CNT_W    = (WPB > 1) ? $clog2(WPB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPB - 1);

   localparam logic [0:0] SEEK   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]                      state;
   logic [0:0]                      state_next;
   logic [CNT_W-1:0]                word_cnt;
   logic [CNT_W-1:0]                cnt_next;
   logic [FEC_WIDTH-1:0]            lfsr [NUM_LANES];
   logic [NUM_LANES*FEC_WIDTH-1:0]  lfsr_next;
   logic                            accept;
   logic                            blk_begin;
   logic                            blk_cont;
   logic                            blk_last;
   logic                            frame_err;

   // Bit 0 of the lane word is shifted in first; the LFSR MSB is the feedback tap.
   function automatic logic [FEC_WIDTH-1:0] lfsr_update(
      input logic [FEC_WIDTH-1:0]  cur,
      input logic [DATA_WIDTH-1:0] din
   );
      logic [FEC_WIDTH-1:0] r;
      logic                 fb;
      r = cur;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         fb = din[i] ^ r[FEC_WIDTH-1];
         r  = {r[FEC_WIDTH-2:0], 1'b0} ^ (fb ? FEC_POLY : {FEC_WIDTH{1'b0}});
      end
      return r;
   endfunction

   assign bus.s_ready = !bus.m_valid || bus.m_ready;
   assign accept      = bus.s_valid && bus.s_ready;

   always_comb begin
      blk_begin  = 1'b0;
      blk_cont   = 1'b0;
      frame_err  = 1'b0;
      state_next = state;
      if (state == SEEK) begin
         blk_begin = bus.s_start;
      end else if (word_cnt == '0) begin
         if (bus.s_start) begin
            blk_begin = 1'b1;
         end else begin
            frame_err  = 1'b1;
            state_next = SEEK;
         end
      end else if (bus.s_start) begin
         // Early start marker: drop the partial block and restart on this beat.
         frame_err = 1'b1;
         blk_begin = 1'b1;
      end else begin
         blk_cont = 1'b1;
      end
      if (blk_begin) begin
         state_next = LOCKED;
      end

      blk_last = (blk_begin && (WPB == 1)) || (blk_cont && (word_cnt == CNT_LAST));

      if (blk_last) begin
         cnt_next = '0;
      end else if (blk_begin) begin
         cnt_next = CNT_W'(1);
      end else if (blk_cont) begin
         cnt_next = word_cnt + CNT_W'(1);
      end else begin
         cnt_next = word_cnt;
      end
   end

   generate
      for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
         assign lfsr_next[n*FEC_WIDTH +: FEC_WIDTH] =
            lfsr_update(blk_begin ? {FEC_WIDTH{1'b0}} : lfsr[n],
                        bus.s_data[n*DATA_WIDTH +: DATA_WIDTH]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= SEEK;
         word_cnt      <= '0;
         bus.m_valid   <= 1'b0;
         bus.m_last    <= 1'b0;
         bus.m_data    <= '0;
         bus.m_fec     <= '0;
         bus.align_err <= 1'b0;
         for (int n = 0; n < NUM_LANES; n++) begin
            lfsr[n] <= '0;
         end
      end else begin
         // Pulses only in the first cycle the offending beat is presented.
         bus.align_err <= accept && frame_err;
         if (accept) begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= bus.s_data;
            bus.m_last  <= blk_last;
            if (blk_last) begin
               bus.m_fec <= lfsr_next;
            end
            state    <= state_next;
            word_cnt <= cnt_next;
            if (blk_begin || blk_cont) begin
               for (int n = 0; n < NUM_LANES; n++) begin
                  lfsr[n] <= lfsr_next[n*FEC_WIDTH +: FEC_WIDTH];
               end
            end
         end else if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jesd204_fec_encode_multilane.sv
// ---------------------------------------------------------------------------
// tb_jesd204_fec_encode_multilane : randomized bench with a polynomial-division reference
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jesd204_fec_encode_multilane;

   typedef struct {
      logic [255:0] data;
      logic         last;
      logic [103:0] fec;
      logic         err;
   } exp_t;

   logic clk;
   logic rst;

   jesd204_fec_encode_multilane_if #(.NUM_LANES(4), .DATA_WIDTH(64), .FEC_WIDTH(26)) bus_a ();
   jesd204_fec_encode_multilane_if #(.NUM_LANES(1), .DATA_WIDTH(32), .FEC_WIDTH(26)) bus_b ();

   jesd204_fec_encode_multilane #(
      .NUM_LANES(4), .DATA_WIDTH(64), .BLOCK_BITS(2048), .FEC_WIDTH(26), .FEC_POLY(26'h0220211)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   jesd204_fec_encode_multilane #(
      .NUM_LANES(1), .DATA_WIDTH(32), .BLOCK_BITS(2048), .FEC_WIDTH(26), .FEC_POLY(26'h0220211)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   int           n_cmp = 0;
   int           n_bad = 0;
   bit           gaps = 0;
   exp_t         q_a[$];
   exp_t         q_b[$];
   exp_t         ea, eb;
   bit           lk [2];
   int           cn [2];
   logic [255:0] blk [2][64];
   int           pulses_a = 0, pulses_b = 0, nlast_a = 0, nlast_b = 0;
   logic [103:0] last_fec_a = '0, last_fec_b = '0;
   bit           err_flag_a = 0, err_flag_b = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference parity: long division of M(x)*x^26 by the full 27-bit generator.
   function automatic logic [25:0] ref_parity(input int u, input int lane);
      logic [2079:0] p;
      logic [26:0]   g;
      int            dw, wpb, len, k;
      g   = 27'h4220211;
      dw  = (u == 0) ? 64 : 32;
      wpb = 2048 / dw;
      len = wpb * dw;
      p   = '0;
      for (int b = 0; b < wpb; b++) begin
         for (int i = 0; i < dw; i++) begin
            k = b * dw + i;
            p[len - 1 - k + 26] = blk[u][b][lane*dw + i];
         end
      end
      for (int d = len + 25; d >= 26; d--) begin
         if (p[d]) p[d-26 +: 27] = p[d-26 +: 27] ^ g;
      end
      return p[25:0];
   endfunction

   task automatic model_beat(input int u, input logic [255:0] d, input logic st);
      exp_t e;
      bit   enc;
      int   wpb, lanes;
      wpb   = (u == 0) ? 32 : 64;
      lanes = (u == 0) ? 4 : 1;
      e.data = d; e.last = 0; e.err = 0; e.fec = '0;
      enc = 0;
      if (!lk[u]) begin
         if (st) begin cn[u] = 0; enc = 1; lk[u] = 1; end
      end else if (cn[u] == 0) begin
         if (st) enc = 1;
         else begin e.err = 1; lk[u] = 0; end
      end else begin
         if (st) begin e.err = 1; cn[u] = 0; end
         enc = 1;
      end
      if (enc) begin
         blk[u][cn[u]] = d;
         cn[u]++;
         if (cn[u] == wpb) begin
            e.last = 1;
            for (int l = 0; l < lanes; l++) e.fec[l*26 +: 26] = ref_parity(u, l);
            cn[u] = 0;
         end
      end
      if (u == 0) q_a.push_back(e); else q_b.push_back(e);
   endtask

   function automatic logic [255:0] rnd_data(input int u);
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      if (u == 1) d[255:32] = '0;
      return d;
   endfunction

   task automatic send(input int u, input logic [255:0] d, input logic st);
      int  idle, n;
      bit  acc;
      idle = gaps ? $urandom_range(0, 2) : 0;
      repeat (idle) begin @(posedge clk); #1; end
      if (u == 0) begin bus_a.s_valid = 1; bus_a.s_start = st; bus_a.s_data = d; end
      else        begin bus_b.s_valid = 1; bus_b.s_start = st; bus_b.s_data = d[31:0]; end
      n = 0;
      forever begin
         @(negedge clk);
         acc = (u == 0) ? bus_a.s_ready : bus_b.s_ready;
         @(posedge clk); #1;
         if (acc) break;
         n++;
         if (n > 1000) begin check("accept_timeout", 1, 0); break; end
      end
      if (u == 0) bus_a.s_valid = 0; else bus_b.s_valid = 0;
      if (acc) model_beat(u, d, st);
   endtask

   task automatic send_block(input int u, input int nbeats);
      for (int b = 0; b < nbeats; b++) send(u, rnd_data(u), b == 0);
   endtask

   task automatic do_reset();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      lk[0] = 0; lk[1] = 0; cn[0] = 0; cn[1] = 0;
      q_a.delete(); q_b.delete();
      err_flag_a = 0; err_flag_b = 0;
      check("rst_mvalid_a", bus_a.m_valid, 0);
      check("rst_mvalid_b", bus_b.m_valid, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      check("drain_a", q_a.size(), 0);
      check("drain_b", q_b.size(), 0);
   endtask

   always @(posedge clk) begin
      #1;
      bus_a.m_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus_b.m_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   always @(negedge clk) begin
      if (!rst && bus_a.align_err) begin err_flag_a = 1; pulses_a++; end
      if (!rst && bus_a.m_valid && bus_a.m_ready) begin
         if (q_a.size() == 0) check("a_unexpected_beat", 1, 0);
         else begin
            ea = q_a.pop_front();
            check("a_data", bus_a.m_data, ea.data);
            check("a_last", bus_a.m_last, ea.last);
            check("a_err", err_flag_a, ea.err);
            if (ea.last) begin
               check("a_fec", bus_a.m_fec, ea.fec);
               last_fec_a = bus_a.m_fec;
               nlast_a++;
            end
         end
         err_flag_a = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && bus_b.align_err) begin err_flag_b = 1; pulses_b++; end
      if (!rst && bus_b.m_valid && bus_b.m_ready) begin
         if (q_b.size() == 0) check("b_unexpected_beat", 1, 0);
         else begin
            eb = q_b.pop_front();
            check("b_data", bus_b.m_data, eb.data);
            check("b_last", bus_b.m_last, eb.last);
            check("b_err", err_flag_b, eb.err);
            if (eb.last) begin
               check("b_fec", bus_b.m_fec, eb.fec);
               last_fec_b = {78'b0, bus_b.m_fec};
               nlast_b++;
            end
         end
         err_flag_b = 0;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] d;
      rst = 1;
      bus_a.s_valid = 0; bus_a.s_start = 0; bus_a.s_data = '0; bus_a.m_ready = 1;
      bus_b.s_valid = 0; bus_b.s_start = 0; bus_b.s_data = '0; bus_b.m_ready = 1;
      lk[0] = 0; lk[1] = 0; cn[0] = 0; cn[1] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      check("reset_m_valid", bus_a.m_valid, 0);
      check("reset_s_ready", bus_a.s_ready, 1);
      check("reset_m_last", bus_a.m_last, 0);
      check("reset_m_data", bus_a.m_data, 0);
      check("reset_m_fec", bus_a.m_fec, 0);
      check("reset_align_err", bus_a.align_err, 0);

      // Beats before any start marker are forwarded silently.
      for (int i = 0; i < 3; i++) send(0, rnd_data(0), 0);
      drain();
      check("seek_no_err", pulses_a, 0);
      check("seek_no_last", nlast_a, 0);

      // All-zero block.
      for (int b = 0; b < 32; b++) send(0, '0, b == 0);
      drain();
      check("zero_nlast", nlast_a, 1);
      check("zero_fec", last_fec_a, 0);
      check("zero_no_err", pulses_a, 0);

      // Missing start after a completed block, then one more unframed beat.
      send(0, rnd_data(0), 0);
      send(0, rnd_data(0), 0);
      drain();
      check("missing_start_err", pulses_a, 1);

      // Only the last-shifted bit of lane 0 set.
      for (int b = 0; b < 32; b++) begin
         d = '0;
         if (b == 31) d[63] = 1'b1;
         send(0, d, b == 0);
      end
      drain();
      check("single_bit_fec", last_fec_a, 104'h0220211);
      check("single_bit_nlast", nlast_a, 2);

      // Start marker at beat 10 aborts the block.
      for (int b = 0; b < 10; b++) send(0, rnd_data(0), b == 0);
      send_block(0, 32);
      drain();
      check("abort_err", pulses_a, 2);
      check("abort_nlast", nlast_a, 3);

      // Random blocks with bubbles on both sides.
      gaps = 1;
      for (int k = 0; k < 100; k++) send_block(0, 32);
      drain();
      check("random_nlast", nlast_a, 103);
      check("random_no_err", pulses_a, 2);

      // Reset mid-block, then a clean block.
      for (int b = 0; b < 20; b++) send(0, rnd_data(0), b == 0);
      do_reset();
      send_block(0, 32);
      drain();
      check("rst_clean_nlast", nlast_a, 104);

      // Narrow single-lane instance: 64 beats per block.
      for (int b = 0; b < 20; b++) send(1, rnd_data(1), b == 0);
      do_reset();
      send_block(1, 64);
      for (int k = 0; k < 3; k++) send_block(1, 64);
      drain();
      check("b_nlast", nlast_b, 4);
      check("b_no_err", pulses_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/jesd204_fec_encode_multilane.md
Name: jesd204_fec_encode_multilane

Overview:
Multi-lane JESD204C 64B/66B FEC parity generator. It computes the 26-bit shortened-cyclic-code parity, g(x)=x^26+x^21+x^17+x^9+x^4+1, over each 2048-bit data block, independently for NUM_LANES lanes. Block framing is tracked internally from a start-of-block marker, and data is passed through with valid/ready backpressure. The block sits in the TX link layer between the scrambler output and the 66-bit sync-header/FEC insertion stage.

Parameters:
NUM_LANES, 4, number of independent lanes; all lanes share one framing counter.
DATA_WIDTH, 64, bits per lane per beat; must divide BLOCK_BITS (legal values 32, 64, 128, 256).
BLOCK_BITS, 2048, data bits per FEC block.
FEC_WIDTH, 26, parity width.
FEC_POLY, 26'h0220211, generator polynomial coefficients x^25..x^0 (the x^26 term is implicit).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_start  in  1  beat is the first beat of a block (all lanes)
s_data  in  NUM_LANES*DATA_WIDTH  lane n in [n*DATA_WIDTH +: DATA_WIDTH]; bit 0 of each lane word is the earliest bit of the block
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  NUM_LANES*DATA_WIDTH  s_data delayed, unmodified
m_last  out  1  beat is the final beat of an encoded block
m_fec  out  NUM_LANES*FEC_WIDTH  per-lane parity; valid only when m_valid && m_last
align_err  out  1  single-cycle pulse on a framing error

Behaviour:
- WPB = BLOCK_BITS/DATA_WIDTH (32 at defaults). word_cnt is ceil(log2(WPB)) bits wide and wraps WPB-1 -> 0.
- Parity per lane = remainder of (block polynomial * x^26) mod g(x). Bit shifted first = highest-order coefficient.
  - Per beat, a DATA_WIDTH-step unrolled LFSR update is applied, consuming bit 0 first through bit DATA_WIDTH-1 last.
  - The result must equal the bit-serial encoder.
- Handshake:
  - s_ready = !m_valid || m_ready. Single output register stage, so latency is exactly 1 cycle from acceptance to m_valid.
  - m_* outputs are held stable while m_valid && !m_ready.
- FSM, two states: SEEK and LOCKED. Only accepted beats change state, word_cnt or LFSRs.
  - SEEK, beat with s_start=0: forwarded with m_last=0; no encoding.
  - SEEK, beat with s_start=1: LFSRs := update(0, data); word_cnt := 1; go LOCKED.
  - LOCKED, s_start=0, word_cnt!=0: LFSRs := update(LFSR, data); word_cnt += 1.
  - LOCKED, word_cnt==WPB-1: the accepted beat is output with m_last=1 and m_fec = post-update LFSRs; word_cnt := 0.
  - LOCKED, word_cnt==0, s_start=1: new block begins (same as SEEK start); no error.
  - LOCKED, word_cnt==0, s_start=0: align_err pulses. Beat is forwarded, not encoded, m_last=0. Go SEEK.
  - LOCKED, word_cnt!=0, s_start=1: align_err pulses. The partial block is discarded with no m_last. This beat starts a new block (LFSRs from 0, word_cnt := 1), and the FSM stays LOCKED.
- align_err is registered and asserts in the cycle the offending beat appears on m_valid.
- WPB==1 (DATA_WIDTH==BLOCK_BITS): the start beat is also the last beat.
- Reset values: m_valid=0, m_last=0, m_data=0, m_fec=0, align_err=0, state=SEEK, word_cnt=0, LFSRs=0. s_ready=1 after reset.
- rst asserted mid-block discards the block. rst has priority over any simultaneous beat.
- The idle bubbles from s_valid=0 or m_ready=0 never advance framing.

Test Plan:
- Block of all-zero data, lanes 0..3 -> m_last on beat 32, m_fec = 0 on every lane, align_err never asserts.
- Lane 0 block with only the last-shifted bit set (bit 63 of beat 31), other lanes zero -> lane 0 m_fec = 26'h0220211, lanes 1..3 = 0.
- 100 random blocks, random s_valid/m_ready gaps -> every lane's m_fec equals the bit-serial reference model; m_data equals s_data in order, with no loss or duplication.
- s_start=1 asserted at beat 10 of a block -> align_err pulses once, no m_last for the aborted block, next m_last 32 beats later with parity of the new block only.
- Beats without s_start after reset -> forwarded with m_last=0 and no align_err; a beat after a completed block without s_start -> align_err, FSM returns to SEEK.
- rst pulsed at beat 20, then a clean block -> m_valid=0 cycle after rst, correct parity for the clean block; repeated with DATA_WIDTH=32 (WPB=64) and NUM_LANES=1.
